rf_dump: RTL and testbench
==========================

RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 SHALL have parameter NREG, default 32: number of registers dumped, indices 0..NREG-1.
REQ-002 SHALL have parameter XLEN, default 32: register width in bits, a multiple of 8.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high from the cycle after start is accepted until the DONE state.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the dump completes.
REQ-008 SHALL have port rf_raddr  output  $clog2(NREG)  register-file read address.
REQ-009 SHALL have port rf_rdata  input  XLEN  register-file read data, valid one cycle after rf_raddr.
REQ-010 SHALL have port tx_valid  output  1  byte-stream valid.
REQ-011 SHALL have port tx_data  output  8  byte-stream data.
REQ-012 SHALL have port tx_ready  input  1  byte-stream ready from the sink.

Function
REQ-013 SHALL implement the states IDLE, READ, SEND, CKSUM and DONE.
REQ-014 IDLE with start=1 SHALL drive rf_raddr=0, set reg_idx=0 and go to READ; start in any other state SHALL be ignored.
REQ-015 READ SHALL last exactly one cycle, capture rf_rdata into a word register, clear byte_idx and go to SEND.
REQ-016 SEND SHALL assert tx_valid with tx_data = word[8*byte_idx +: 8], least significant byte first.
REQ-017 A transfer SHALL occur only on a cycle with tx_valid=1 and tx_ready=1.
REQ-018 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable.
REQ-019 On a transfer with byte_idx < XLEN/8-1, byte_idx SHALL increment.
REQ-020 On a transfer of the last byte with reg_idx < NREG-1, reg_idx and rf_raddr SHALL become reg_idx+1, and the next state SHALL be READ.
REQ-021 On a transfer of the last byte of register NREG-1, the next state SHALL be CKSUM when enabled (REQ-029), else DONE.
REQ-022 Register 0 SHALL be dumped exactly as read; it receives no special casing.
REQ-023 DONE SHALL assert done=1 and busy=0 for one cycle, then go to IDLE; start in DONE SHALL be ignored.
REQ-024 With tx_ready held at 1, register k SHALL occupy cycles 5k+1..5k+5 after the start-accept edge (XLEN=32), and done SHALL assert in cycle 5*NREG+1.
REQ-025 tx_valid SHALL be 0 in IDLE, READ and DONE.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, reg_idx=0, byte_idx=0, rf_raddr=0, tx_valid=0, tx_data=0, busy=0, done=0 and checksum=0.
REQ-027 A reset asserted mid-dump SHALL abort the dump with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-028 The first start after reset release SHALL be accepted on the next rising edge.

Configuration
REQ-029 With macro RF_DUMP_CKSUM_EN defined, the block SHALL XOR-accumulate every transferred byte, clear the accumulator on start-accept, and send the accumulator as one byte in CKSUM; on that transfer it SHALL go to DONE, so done asserts at cycle 5*NREG+2 when tx_ready is held at 1.
REQ-030 With RF_DUMP_CKSUM_EN undefined, the block SHALL contain no CKSUM state and no accumulator, and the stream SHALL be exactly NREG*XLEN/8 bytes.

Verification
REQ-031 rf[i]=i for all i, tx_ready=1, start pulse -> 128 bytes i,00,00,00 in order; rf_raddr steps 0..31; done at cycle 161; busy low at done.
REQ-032 rf[5]=0xDEADBEEF, others 0, RF_DUMP_CKSUM_EN defined -> bytes 20..23 are EF,BE,AD,DE; 129th byte 0x22; done at cycle 162.
REQ-033 tx_ready toggling 1,0,0,1 per cycle -> no byte lost or duplicated; tx_data stable while stalled; byte count is 128.
REQ-034 reset driven low at cycle 50 mid-dump -> all outputs 0 immediately (asynchronously); no done pulse; a new start gives a complete dump from register 0.
REQ-035 start held high through a dump -> exactly one dump before DONE, then a second dump begins on the edge after the return to IDLE.

Source files
------------

// File: rtl/rf_dump_if.sv
// -----------------------------------------------------------------------------
// rf_dump_if -- bundle of the register-dump control, register-file read port and
// byte-stream output used by rf_dump.
//
// Signals:
//   start     dump request (master -> dumper)
//   busy      dump in progress (dumper -> master)
//   done      one-cycle completion pulse (dumper -> master)
//   rf_raddr  register-file read address (dumper -> register file)
//   rf_rdata  register-file read data, valid in the cycle after rf_raddr changes
//   tx_valid  byte-stream valid (dumper -> sink)
//   tx_data   byte-stream data (dumper -> sink)
//   tx_ready  byte-stream ready (sink -> dumper)
//
// Handshake: a byte moves on every rising clock edge where tx_valid and
// tx_ready are both 1. Once tx_valid is raised, it and tx_data stay unchanged
// until that transfer edge; tx_ready may change freely and has no effect
// while tx_valid is 0.
//
// Modports: slave = the dumper side, master = the environment side.
// -----------------------------------------------------------------------------
interface rf_dump_if #(
    parameter int NREG = 32,
    parameter int XLEN = 32
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;

    modport slave (
        input  start, rf_rdata, tx_ready,
        output busy, done, rf_raddr, tx_valid, tx_data
    );

    modport master (
        output start, rf_rdata, tx_ready,
        input  busy, done, rf_raddr, tx_valid, tx_data
    );
endinterface

// File: rtl/rf_dump.sv
// -----------------------------------------------------------------------------
// rf_dump -- walks a register file from index 0 to NREG-1 and streams every
// register out as XLEN/8 bytes, least significant byte first, over a
// valid/ready byte stream. Each register costs one READ cycle followed by
// XLEN/8 SEND cycles when the sink never stalls.
//
// Parameters:
//   NREG  number of registers dumped (indices 0..NREG-1)
//   XLEN  register width in bits, a multiple of 8
//
// Ports:
//   CLK      system clock, rising edge
//   reset    asynchronous active-low reset
//   bus      rf_dump_if.slave: start/busy/done, rf_raddr/rf_rdata,
//            tx_valid/tx_data/tx_ready
//   state_o  current FSM state, for observation only
//
// Optional feature (macro RF_DUMP_CKSUM_EN): XOR of every streamed data byte is
// appended as one extra byte in a CKSUM state before DONE. Without the macro
// the CKSUM state and the accumulator do not exist.
// -----------------------------------------------------------------------------
module rf_dump #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic       CLK,
    input  logic       reset,
    rf_dump_if.slave   bus,
    output logic [2:0] state_o
);
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int NBYTE = XLEN / 8;
    localparam int BW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;

    localparam logic [AW-1:0] LAST_REG  = AW'(NREG - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_SEND  = 3'd2,
`ifdef RF_DUMP_CKSUM_EN
        S_CKSUM = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   reg_idx_q;
    logic [BW-1:0]   byte_idx_q;
    logic [XLEN-1:0] word_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic            busy_q;
    logic            done_q;
`ifdef RF_DUMP_CKSUM_EN
    logic [7:0]      cksum_q;
`endif

    logic            xfer;
    logic [AW-1:0]   reg_idx_d;
    logic [BW-1:0]   byte_idx_d;

    assign xfer       = tx_valid_q && bus.tx_ready;
    assign reg_idx_d  = reg_idx_q + 1'b1;
    assign byte_idx_d = byte_idx_q + 1'b1;

    // reg_idx_q doubles as the read address: the address is presented one
    // cycle ahead of the READ state that captures the data.
    assign bus.rf_raddr = reg_idx_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign state_o      = state_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef RF_DUMP_CKSUM_EN
            cksum_q    <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        reg_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_READ;
`ifdef RF_DUMP_CKSUM_EN
                        cksum_q   <= 8'h00;
`endif
                    end
                end

                S_READ: begin
                    // The first byte is loaded straight from the read data so
                    // tx_data is already correct in the first SEND cycle.
                    word_q     <= bus.rf_rdata;
                    byte_idx_q <= '0;
                    tx_data_q  <= bus.rf_rdata[7:0];
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end

                S_SEND: begin
                    // Without a transfer nothing changes, which keeps tx_data
                    // stable across stalls.
                    if (xfer) begin
`ifdef RF_DUMP_CKSUM_EN
                        cksum_q <= cksum_q ^ tx_data_q;
`endif
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= byte_idx_d;
                            tx_data_q  <= 8'(word_q >> {byte_idx_d, 3'b000});
                        end else if (reg_idx_q != LAST_REG) begin
                            reg_idx_q  <= reg_idx_d;
                            tx_valid_q <= 1'b0;
                            state_q    <= S_READ;
                        end else begin
`ifdef RF_DUMP_CKSUM_EN
                            // Fold in the byte leaving now so the checksum
                            // byte covers the whole data stream.
                            tx_data_q  <= cksum_q ^ tx_data_q;
                            state_q    <= S_CKSUM;
`else
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
`endif
                        end
                    end
                end

`ifdef RF_DUMP_CKSUM_EN
                S_CKSUM: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_dump.sv
// -----------------------------------------------------------------------------
// tb_rf_dump -- directed bench for rf_dump (NREG=32, XLEN=32). Works for both
// builds: with RF_DUMP_CKSUM_EN defined the expected stream gains the checksum
// byte and done moves one cycle later.
// Cycle numbering: cycle 1 is the cycle right after the start-accept edge.
// -----------------------------------------------------------------------------
module tb_rf_dump;
    localparam int NREG = 32;
    localparam int XLEN = 32;
    localparam int NDATA = NREG * XLEN / 8;
`ifdef RF_DUMP_CKSUM_EN
    localparam int NB       = NDATA + 1;
    localparam int DONE_CYC = 5 * NREG + 2;
`else
    localparam int NB       = NDATA;
    localparam int DONE_CYC = 5 * NREG + 1;
`endif

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [2:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // ---------------- DUT ----------------
    rf_dump_if #(.NREG(NREG), .XLEN(XLEN)) bus ();

    rf_dump #(.NREG(NREG), .XLEN(XLEN)) dut (
        .CLK     (clk),
        .reset   (rst_n),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    // Register file: data follows the address within the same cycle.
    logic [XLEN-1:0] rf [NREG];
    assign bus.rf_rdata = rf[bus.rf_raddr];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] rx_log [0:1023];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         n_bytes  = 0;
    bit         chk_raddr = 1'b0;
    bit         stalled_prev = 1'b0;
    logic [7:0] held_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump();
        logic [7:0] x;
        x = 8'h00;
        for (int r = 0; r < NREG; r++) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                exp_q.push_back(rf[r][8*b +: 8]);
                x = x ^ rf[r][8*b +: 8];
            end
        end
`ifdef RF_DUMP_CKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Byte monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev && bus.tx_valid)
                check("stall_hold", 32'(bus.tx_data), 32'(held_data));
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() > 0)
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                else
                    check("tx_extra_byte", 32'(bus.tx_data), 32'h100);
                if (chk_raddr && n_bytes < NDATA)
                    check("rf_raddr", 32'(bus.rf_raddr), 32'(n_bytes / 4));
                if (n_bytes < 1024) rx_log[n_bytes] = bus.tx_data;
                n_bytes = n_bytes + 1;
            end
            stalled_prev = bus.tx_valid && !bus.tx_ready;
            held_data    = bus.tx_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after an edge with the DUT idle; returns at #1 into cycle 1.
    task automatic start_pulse(input bit hold);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Called at #1 into cycle 1; steps cycles applying the tx_ready pattern
    // (MSB first, repeating) until done is seen or the budget runs out.
    task automatic wait_done(input logic [3:0] pat, output int done_cyc);
        int busy_low;
        done_cyc = -1;
        busy_low = 0;
        for (int c = 1; c <= 2000; c++) begin
            bus.tx_ready = pat[3 - ((c - 1) % 4)];
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (!bus.busy) busy_low = busy_low + 1;
            @(posedge clk);
            #1;
        end
        check("done_within_budget", 32'(done_cyc != -1), 32'd1);
        check("busy_high_until_done", 32'(busy_low), 32'd0);
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
        check("tx_valid_low_at_done", 32'(bus.tx_valid), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d;
        int d2;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < NREG; i++) rf[i] = 32'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rf_raddr", 32'(bus.rf_raddr), 32'd0);
        check("rst_state_idle", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_tx_valid", 32'(bus.tx_valid), 32'd0);

        // Dump 1: rf[i]=i, sink always ready
        push_dump();
        n_bytes   = 0;
        chk_raddr = 1'b1;
        start_pulse(1'b0);
        check("d1_busy_cycle1", 32'(bus.busy), 32'd1);
        check("d1_raddr_cycle1", 32'(bus.rf_raddr), 32'd0);
        check("d1_tx_valid_read", 32'(bus.tx_valid), 32'd0);
        wait_done(4'b1111, d);
        check("d1_done_cycle", 32'(d), 32'(DONE_CYC));
        check("d1_byte_count", 32'(n_bytes), 32'(NB));
        check("d1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("d1_byte0", 32'(rx_log[0]), 32'h00);
        check("d1_byte4", 32'(rx_log[4]), 32'h01);
        check("d1_byte5", 32'(rx_log[5]), 32'h00);
        check("d1_byte124", 32'(rx_log[124]), 32'h1F);
        @(posedge clk);
        #1;

        // Dump 2: single non-zero register
        for (int i = 0; i < NREG; i++) rf[i] = 32'h0;
        rf[5] = 32'hDEADBEEF;
        push_dump();
        n_bytes = 0;
        start_pulse(1'b0);
        wait_done(4'b1111, d);
        check("d2_done_cycle", 32'(d), 32'(DONE_CYC));
        check("d2_byte20", 32'(rx_log[20]), 32'hEF);
        check("d2_byte21", 32'(rx_log[21]), 32'hBE);
        check("d2_byte22", 32'(rx_log[22]), 32'hAD);
        check("d2_byte23", 32'(rx_log[23]), 32'hDE);
        check("d2_byte19", 32'(rx_log[19]), 32'h00);
`ifdef RF_DUMP_CKSUM_EN
        check("d2_cksum_byte", 32'(rx_log[128]), 32'h22);
`endif
        check("d2_byte_count", 32'(n_bytes), 32'(NB));
        @(posedge clk);
        #1;

        // Dump 3: sink ready pattern 1,0,0,1
        for (int i = 0; i < NREG; i++) rf[i] = (32'(i) * 32'h11111111) ^ 32'h80402010;
        push_dump();
        n_bytes = 0;
        start_pulse(1'b0);
        wait_done(4'b1001, d);
        check("d3_byte_count", 32'(n_bytes), 32'(NB));
        check("d3_queue_empty", 32'(exp_q.size()), 32'd0);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;

        // Dump 4: reset in cycle 50, then a fresh complete dump
        for (int i = 0; i < NREG; i++) rf[i] = {4{8'(i + 1)}};
        push_dump();
        n_bytes = 0;
        start_pulse(1'b0);
        for (int c = 1; c < 50; c++) begin
            @(posedge clk);
            #1;
        end
        check("d4_pre_rst_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("d4_pre_rst_tx_data", 32'(bus.tx_data), 32'h0A);
        check("d4_pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("d4_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("d4_rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("d4_rst_busy", 32'(bus.busy), 32'd0);
        check("d4_rst_done", 32'(bus.done), 32'd0);
        check("d4_rst_raddr", 32'(bus.rf_raddr), 32'd0);
        check("d4_rst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("d4_in_rst_done_busy", {30'd0, bus.done, bus.busy}, 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("d4_post_rst_idle", {29'd0, bus.done, bus.busy, bus.tx_valid}, 32'd0);
        end
        push_dump();
        n_bytes = 0;
        start_pulse(1'b0);
        check("d4_accept_busy", 32'(bus.busy), 32'd1);
        wait_done(4'b1111, d);
        check("d4_done_cycle", 32'(d), 32'(DONE_CYC));
        check("d4_byte_count", 32'(n_bytes), 32'(NB));
        check("d4_byte0", 32'(rx_log[0]), 32'h01);
        check("d4_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Dump 5: start held high through a dump
        for (int i = 0; i < NREG; i++) rf[i] = 32'hA5000000 | (32'(i) * 32'd3);
        push_dump();
        push_dump();
        n_bytes   = 0;
        chk_raddr = 1'b0;
        start_pulse(1'b1);
        wait_done(4'b1111, d);
        check("d5_first_done_cycle", 32'(d), 32'(DONE_CYC));
        check("d5_first_byte_count", 32'(n_bytes), 32'(NB));
        @(posedge clk);
        #1;
        check("d5_idle_after_done", {30'd0, bus.done, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("d5_second_busy", 32'(bus.busy), 32'd1);
        check("d5_second_raddr", 32'(bus.rf_raddr), 32'd0);
        wait_done(4'b1111, d2);
        check("d5_second_done_cycle", 32'(d2), 32'(DONE_CYC));
        check("d5_total_bytes", 32'(n_bytes), 32'(2 * NB));
        check("d5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Final report
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
